// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I memory stage.
// Provides the load/store size encodings, the Result-mux select encoding,
// the LSU state enum, and helpers that check alignment and form store
// byte enables / lane-replicated store data.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101
  } Load_Type_Case;

  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } Store_Type_Case;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } Result_Mux_Case;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } LSU_State;

  // Undefined size encodings report as misaligned so they never reach memory.
  function automatic logic access_ok(input logic is_load, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (is_load) begin
      case (f3)
        LT_LB, LT_LBU: ok = 1'b1;
        LT_LH, LT_LHU: ok = ~off[0];
        LT_LW:         ok = (off == 2'b00);
        default:       ok = 1'b0;
      endcase
    end else begin
      case (f3)
        ST_SB:   ok = 1'b1;
        ST_SH:   ok = ~off[0];
        ST_SW:   ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      ST_SB:   be = 4'b0001 << off;
      ST_SH:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rd2);
    logic [31:0] wd;
    case (f3)
      ST_SB:   wd = {4{rd2[7:0]}};
      ST_SH:   wd = {2{rd2[15:0]}};
      default: wd = rd2;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// load_extend: combinational lane select and sign/zero extension of a
// 32-bit read word.
//   rdata  : word returned by memory
//   off    : byte offset within the word (address bits [1:0])
//   funct3 : load size / signedness (Load_Type_Case)
//   data   : extended load result (0 for undefined encodings)
module load_extend
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{off, 3'b000} +: 8];
    half_lane = rdata[{off[1], 4'b0000} +: 16];
    case (funct3)
      LT_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      LT_LBU:  data = {24'h000000, byte_lane};
      LT_LH:   data = {{16{half_lane[15]}}, half_lane};
      LT_LHU:  data = {16'h0000, half_lane};
      LT_LW:   data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: Memory stage of the 5-stage RV32I pipeline.
// Takes Execute results (in_*), runs a req/ready handshake to data memory
// for aligned loads/stores, and registers Writeback operands (out_*).
//   stall          : freeze upstream stages (issue cycle and REQ wait cycles)
//   dmem_*         : request/ready data-memory port, word-aligned address,
//                    byte enables and lane-replicated store data
//   out_*          : Writeback slot, out_load_data is the extended load word
//   out_misaligned : one-cycle flag for a misaligned/undefined access
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_alu_result,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [31:0]       in_pc4,
  input  logic [4:0]        in_a3,
  input  logic              in_regw,
  input  logic [1:0]        in_result_sel,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              out_valid,
  output logic [31:0]       out_alu_result,
  output logic [DATA_W-1:0] out_load_data,
  output logic [31:0]       out_pc4,
  output logic [4:0]        out_a3,
  output logic              out_regw,
  output logic [1:0]        out_result_sel,
  output logic              out_misaligned
);

  LSU_State state, state_nxt;

  logic       is_mem_p0, is_load_p0, aligned_p0, issue_p0;
  logic [1:0] off_p0;

  logic [ADDR_W-1:0] req_addr_p1;
  logic [1:0]        req_off_p1;
  logic [2:0]        req_funct3_p1;
  logic              req_we_p1;
  logic [3:0]        req_be_p1;
  logic [DATA_W-1:0] req_wdata_p1;
  logic [31:0]       req_alu_p1;
  logic [31:0]       req_pc4_p1;
  logic [4:0]        req_a3_p1;
  logic              req_regw_p1;
  logic [1:0]        req_sel_p1;
  logic [DATA_W-1:0] load_ext_p1;

  // ---- Stage p0: decode the Execute slot ----
  // A simultaneous read+write is treated as a read.
  assign is_mem_p0  = in_valid & (in_mem_read | in_mem_write);
  assign is_load_p0 = in_mem_read;
  assign off_p0     = in_alu_result[1:0];
  assign aligned_p0 = access_ok(is_load_p0, in_funct3, off_p0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    issue_p0  = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem_p0 && aligned_p0) begin
          issue_p0  = 1'b1;
          stall     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // Upstream advances in the completion cycle.
        stall = ~dmem_ready;
        if (dmem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- Stage p1: request register, held stable while in REQ ----
  always_ff @(posedge clk) begin
    if (issue_p0) begin
      req_addr_p1   <= {in_alu_result[ADDR_W-1:2], 2'b00};
      req_off_p1    <= off_p0;
      req_funct3_p1 <= in_funct3;
      req_we_p1     <= ~is_load_p0;
      req_be_p1     <= is_load_p0 ? 4'b1111 : store_be(in_funct3, off_p0);
      req_wdata_p1  <= store_wdata(in_funct3, in_rd2);
      req_alu_p1    <= in_alu_result;
      req_pc4_p1    <= in_pc4;
      req_a3_p1     <= in_a3;
      req_regw_p1   <= in_regw;
      req_sel_p1    <= in_result_sel;
    end
  end

  assign dmem_req   = (state == REQ);
  assign dmem_we    = dmem_req & req_we_p1;
  assign dmem_addr  = req_addr_p1;
  assign dmem_be    = req_be_p1;
  assign dmem_wdata = req_wdata_p1;

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .rdata  (dmem_rdata),
    .off    (req_off_p1),
    .funct3 (req_funct3_p1),
    .data   (load_ext_p1)
  );

  // ---- Stage p2: Writeback register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_misaligned <= 1'b0;
      out_regw       <= 1'b0;
      out_alu_result <= '0;
      out_load_data  <= '0;
      out_pc4        <= '0;
      out_a3         <= '0;
      out_result_sel <= '0;
    end else if (state == IDLE) begin
      out_valid      <= in_valid & ~issue_p0;
      out_misaligned <= is_mem_p0 & ~aligned_p0;
      out_regw       <= in_valid & in_regw & ~is_mem_p0;
      out_alu_result <= in_alu_result;
      out_load_data  <= '0;
      out_pc4        <= in_pc4;
      out_a3         <= in_a3;
      out_result_sel <= in_result_sel;
    end else begin
      out_misaligned <= 1'b0;
      out_valid      <= dmem_ready;
      out_regw       <= dmem_ready & req_regw_p1;
      if (dmem_ready) begin
        out_alu_result <= req_alu_p1;
        out_load_data  <= req_we_p1 ? '0 : load_ext_p1;
        out_pc4        <= req_pc4_p1;
        out_a3         <= req_a3_p1;
        out_result_sel <= req_sel_p1;
      end
    end
  end

endmodule
